mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit_if.sv | 34 +++
 rtl/mem_access_unit.sv | 121 ++++++++++++
 tb/tb_mem_access_unit.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// Memory access unit bus bundle.
// CU handshake side plus byte-wide RAM side.
interface mem_access_unit_if;
    // CU side
    logic        MOV;
    logic        RW;
    logic        typeData;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic        MOC;
    logic [31:0] rdata;
    logic        err;
    // RAM side
    logic        ram_mov;
    logic        ram_rw;
    logic [7:0]  ram_addr;
    logic [7:0]  ram_din;
    logic [7:0]  ram_dout;
    logic        ram_moc;

    modport master (
        output MOV, RW, typeData, addr, wdata,
        output ram_dout, ram_moc,
        input  MOC, rdata, err,
        input  ram_mov, ram_rw, ram_addr, ram_din
    );

    modport slave (
        input  MOV, RW, typeData, addr, wdata,
        input  ram_dout, ram_moc,
        output MOC, rdata, err,
        output ram_mov, ram_rw, ram_addr, ram_din
    );
endinterface

// File: rtl/mem_access_unit.sv
// Memory access unit: splits CU byte/word requests
// into big-endian byte handshakes to a ram256x8.
module mem_access_unit (
    input  logic             CLK,
    input  logic             CLR,
    mem_access_unit_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        REL  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [1:0]  r_idx;
    logic        r_rw;
    logic        r_type;
    logic [7:0]  r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic        r_err;

    logic [1:0]  w_last;
    logic [1:0]  w_lane;
    logic        w_misalign;

    // Word transfers walk 4 bytes, byte transfers one.
    // Byte idx of a word maps to lane 3-idx (big-endian);
    // a single byte always lives in lane 0.
    assign w_last     = r_type ? 2'd3 : 2'd0;
    assign w_lane     = r_type ? (2'd3 - r_idx) : 2'd0;
    assign w_misalign = bus.typeData && (bus.addr[1:0] != 2'b00);

    // State register.
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic for the byte handshake sequencer.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (bus.MOV) begin
                    w_next = w_misalign ? DONE : REQ;
                end
            end
            REQ: begin
                if (bus.ram_moc) begin
                    w_next = REL;
                end
            end
            REL: begin
                if (!bus.ram_moc) begin
                    w_next = (r_idx == w_last) ? DONE : REQ;
                end
            end
            DONE: begin
                if (!bus.MOV) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Request latch, byte counter and read assembly.
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            r_idx   <= 2'd0;
            r_rw    <= 1'b1;
            r_type  <= 1'b0;
            r_addr  <= 8'h00;
            r_wdata <= 32'h0;
            r_rdata <= 32'h0;
            r_err   <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (bus.MOV) begin
                        r_rw    <= bus.RW;
                        r_type  <= bus.typeData;
                        r_addr  <= bus.addr;
                        r_wdata <= bus.wdata;
                        r_idx   <= 2'd0;
                        r_rdata <= 32'h0;
                        r_err   <= w_misalign;
                    end
                end
                REQ: begin
                    if (bus.ram_moc && r_rw) begin
                        r_rdata[{w_lane, 3'b000} +: 8] <= bus.ram_dout;
                    end
                end
                REL: begin
                    if (!bus.ram_moc && (r_idx != w_last)) begin
                        r_idx <= r_idx + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // ram_mov comes straight from the state so reset kills it at once.
    assign bus.MOC      = (r_state == DONE);
    assign bus.rdata    = r_rdata;
    assign bus.err      = r_err;
    assign bus.ram_mov  = (r_state == REQ);
    assign bus.ram_rw   = r_rw;
    assign bus.ram_addr = r_addr + {6'b0, r_idx};
    assign bus.ram_din  = r_wdata[{w_lane, 3'b000} +: 8];

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: byte RAM with
// programmable delay and a shadow memory model.
module tb_mem_access_unit;

    logic CLK = 1'b0;
    logic CLR = 1'b0;
    always #5 CLK = ~CLK;

    mem_access_unit_if bus ();

    mem_access_unit dut (
        .CLK (CLK),
        .CLR (CLR),
        .bus (bus)
    );

    // RAM model
    logic [7:0] ram [256];
    logic [7:0] mdl [256];
    int         ram_delay = 0;
    int         cnt = 0;
    logic       moc_q = 1'b0;
    int         pulses = 0;
    logic       pl_en = 1'b0;
    logic       pl_clr = 1'b0;
    logic [7:0] pl_a = 8'h00;
    logic [7:0] pl_d = 8'h00;

    // RAM storage, preload port and delayed completion
    always @(posedge CLK) begin
        if (pl_clr) begin
            for (int i = 0; i < 256; i++) ram[i] <= 8'h00;
        end else if (pl_en) begin
            ram[pl_a] <= pl_d;
        end else if (bus.ram_mov && bus.ram_moc && !bus.ram_rw) begin
            ram[bus.ram_addr] <= bus.ram_din;
        end
        if (bus.ram_mov) begin
            if (cnt >= ram_delay - 1) moc_q <= 1'b1;
            else cnt <= cnt + 1;
        end else begin
            cnt   <= 0;
            moc_q <= 1'b0;
        end
    end

    assign bus.ram_moc  = (ram_delay == 0) ? bus.ram_mov : moc_q;
    assign bus.ram_dout = ram[bus.ram_addr];

    // Count byte request pulses
    always @(posedge bus.ram_mov) pulses++;

    int          n_chk = 0;
    int          n_fail = 0;
    logic        exp_valid = 1'b0;
    logic [31:0] exp_rdata = 32'h0;
    logic        exp_err = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Continuous compare while MOC is up
    always @(negedge CLK) begin
        if (CLR && exp_valid && bus.MOC) begin
            chk("done_rdata", bus.rdata, exp_rdata);
            chk("done_err", {31'b0, bus.err}, {31'b0, exp_err});
            chk("done_ram_mov", {31'b0, bus.ram_mov}, 32'd0);
        end
    end

    task automatic preload(input logic [7:0] a, input logic [7:0] d);
        @(negedge CLK);
        pl_a  = a;
        pl_d  = d;
        pl_en = 1'b1;
        @(negedge CLK);
        pl_en = 1'b0;
        mdl[a] = d;
    endtask

    task automatic clear_mem();
        @(negedge CLK);
        pl_clr = 1'b1;
        @(negedge CLK);
        pl_clr = 1'b0;
        for (int i = 0; i < 256; i++) mdl[i] = 8'h00;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_moc"}, {31'b0, bus.MOC}, 32'd0);
        chk({tag, "_err"}, {31'b0, bus.err}, 32'd0);
        chk({tag, "_rdata"}, bus.rdata, 32'd0);
        chk({tag, "_ram_mov"}, {31'b0, bus.ram_mov}, 32'd0);
        chk({tag, "_ram_rw"}, {31'b0, bus.ram_rw}, 32'd1);
        chk({tag, "_ram_addr"}, {24'b0, bus.ram_addr}, 32'd0);
        chk({tag, "_ram_din"}, {24'b0, bus.ram_din}, 32'd0);
    endtask

    task automatic op(input logic rw, input logic ty,
                      input logic [7:0] a, input logic [31:0] wd,
                      input int hold,
                      output int lat, output int np,
                      output logic [31:0] rd, output logic er);
        logic mis;
        logic got;
        int   p0;
        mis = ty && (a[1:0] != 2'b00);
        exp_err   = mis;
        exp_rdata = 32'h0;
        if (rw && !mis) begin
            if (ty)
                exp_rdata = {mdl[a], mdl[8'(a + 8'd1)],
                             mdl[8'(a + 8'd2)], mdl[8'(a + 8'd3)]};
            else
                exp_rdata = {24'h0, mdl[a]};
        end
        exp_valid = 1'b1;
        p0  = pulses;
        rd  = 32'h0;
        er  = 1'b0;
        @(negedge CLK);
        bus.MOV      = 1'b1;
        bus.RW       = rw;
        bus.typeData = ty;
        bus.addr     = a;
        bus.wdata    = wd;
        lat = 0;
        got = 1'b0;
        for (int k = 0; k < 300 && !got; k++) begin
            @(posedge CLK);
            #1;
            lat++;
            if (bus.MOC) begin
                got = 1'b1;
                rd  = bus.rdata;
                er  = bus.err;
            end
        end
        chk("moc_seen", {31'b0, got}, 32'd1);
        if (ram_delay == 0)
            chk("latency", lat, mis ? 1 : 1 + 2 * (ty ? 4 : 1));
        for (int k = 0; k < hold; k++) begin
            @(posedge CLK);
            #1;
            chk("moc_hold", {31'b0, bus.MOC}, 32'd1);
        end
        @(negedge CLK);
        bus.MOV = 1'b0;
        @(posedge CLK);
        #1;
        chk("moc_release", {31'b0, bus.MOC}, 32'd0);
        np = pulses - p0;
        chk("pulse_count", np, mis ? 0 : (ty ? 4 : 1));
        exp_valid = 1'b0;
        if (!rw && !mis) begin
            if (ty) begin
                mdl[a]              = wd[31:24];
                mdl[8'(a + 8'd1)]   = wd[23:16];
                mdl[8'(a + 8'd2)]   = wd[15:8];
                mdl[8'(a + 8'd3)]   = wd[7:0];
            end else begin
                mdl[a] = wd[7:0];
            end
        end
    endtask

    int          lat;
    int          np;
    logic [31:0] rd;
    logic        er;
    int          p0;

    initial begin
        bus.MOV      = 1'b0;
        bus.RW       = 1'b1;
        bus.typeData = 1'b0;
        bus.addr     = 8'h00;
        bus.wdata    = 32'h0;
        clear_mem();
        preload(8'h10, 8'hE2);
        preload(8'h11, 8'h01);
        preload(8'h12, 8'h00);
        preload(8'h13, 8'h00);
        preload(8'hFF, 8'h5C);
        #1;
        chk_reset_outputs("rst");
        @(negedge CLK);
        CLR = 1'b1;

        // Word read
        op(1'b1, 1'b1, 8'h10, 32'h0, 2, lat, np, rd, er);
        chk("wr10_lat", lat, 9);
        chk("wr10_rdata", rd, 32'hE201_0000);
        chk("wr10_err", {31'b0, er}, 32'd0);

        // Byte read
        op(1'b1, 1'b0, 8'h11, 32'h0, 0, lat, np, rd, er);
        chk("br11_lat", lat, 3);
        chk("br11_rdata", rd, 32'h0000_0001);

        // Word write then read back
        op(1'b0, 1'b1, 8'h20, 32'hDEAD_BEEF, 0, lat, np, rd, er);
        chk("ww20_lat", lat, 9);
        chk("ram20", {ram[8'h20], ram[8'h21], ram[8'h22], ram[8'h23]},
            32'hDEAD_BEEF);
        op(1'b1, 1'b1, 8'h20, 32'h0, 0, lat, np, rd, er);
        chk("wr20_rdata", rd, 32'hDEAD_BEEF);

        // Misaligned word
        op(1'b1, 1'b1, 8'h22, 32'h0, 1, lat, np, rd, er);
        chk("mis22_lat", lat, 1);
        chk("mis22_err", {31'b0, er}, 32'd1);
        chk("mis22_pulses", np, 0);

        // Byte write, byte and word read around it
        op(1'b0, 1'b0, 8'h31, 32'h1234_56A5, 0, lat, np, rd, er);
        chk("ram31", {24'b0, ram[8'h31]}, 32'h0000_00A5);
        op(1'b1, 1'b0, 8'h31, 32'h0, 0, lat, np, rd, er);
        chk("br31_rdata", rd, 32'h0000_00A5);
        op(1'b1, 1'b1, 8'h30, 32'h0, 0, lat, np, rd, er);
        chk("wr30_rdata", rd, 32'h00A5_0000);

        // Top of address space
        op(1'b1, 1'b0, 8'hFF, 32'h0, 0, lat, np, rd, er);
        chk("brFF_rdata", rd, 32'h0000_005C);

        // Slow RAM
        ram_delay = 3;
        op(1'b1, 1'b1, 8'h20, 32'h0, 3, lat, np, rd, er);
        chk("slow_pulses", np, 4);
        chk("slow_rdata", rd, 32'hDEAD_BEEF);
        op(1'b0, 1'b1, 8'h40, 32'h0102_0304, 0, lat, np, rd, er);
        op(1'b1, 1'b1, 8'h40, 32'h0, 0, lat, np, rd, er);
        chk("slow_wr40", rd, 32'h0102_0304);
        ram_delay = 0;

        // Reset in the middle of a word read
        p0 = pulses;
        @(negedge CLK);
        bus.MOV      = 1'b1;
        bus.RW       = 1'b1;
        bus.typeData = 1'b1;
        bus.addr     = 8'h10;
        for (int k = 0; k < 50 && (pulses - p0) < 2; k++) @(posedge CLK);
        chk("abort_reached", pulses - p0, 2);
        #2;
        CLR = 1'b0;
        #1;
        chk_reset_outputs("abort");
        bus.MOV = 1'b0;
        @(negedge CLK);
        CLR = 1'b1;
        @(posedge CLK);
        #1;
        chk("abort_no_moc", {31'b0, bus.MOC}, 32'd0);
        op(1'b1, 1'b1, 8'h10, 32'h0, 0, lat, np, rd, er);
        chk("post_rst_rdata", rd, 32'hE201_0000);
        chk("post_rst_lat", lat, 9);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
